// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Segment patterns are {g,f,e,d,c,b,a}, active-low, indexed by nibble value.
package seg7_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } seg7_state_e;

    localparam int NUM_DIGITS = 8;
    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Entry 15 first so that SEG_PAT[n] is the pattern for nibble n.
    localparam logic [15:0][6:0] SEG_PAT = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-low seven-segment pattern {g..a}.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] pat_o
);

    assign pat_o = SEG_PAT[nib_i];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Eight-digit seven-segment scan controller with frame-aligned shadow update.
// Define SEG7_LZB_EN to blank leading-zero digits (digit 0 is always shown).
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int DIGIT_CYC = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        upd_valid,
    input  logic [31:0] upd_data,
    output logic        upd_ready,
    output logic [7:0]  o_seg,
    output logic [7:0]  o_sel,
    output logic        frame_done
);

    localparam int MAX_CYC = (DIGIT_CYC > BLANK_CYC) ? DIGIT_CYC : BLANK_CYC;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    seg7_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [31:0]   disp_q, disp_d;
    logic [31:0]   shadow_q, shadow_d;
    logic          shadow_full_q, shadow_full_d;
    logic [7:0]    sel_q, sel_d;
    logic [7:0]    seg_q, seg_d;
    logic          frame_done_q, frame_done_d;
    logic [3:0]    nib;
    logic [6:0]    pat;

`ifdef SEG7_LZB_EN
    logic [7:0]    blank_mask;

    // Bit i set when nibbles i..7 are all zero; digit 0 never blanks.
    function automatic logic [7:0] lzb_mask(input logic [31:0] v);
        logic [7:0] m;
        logic       zero_above;
        m          = '0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above && (v[4*i +: 4] == 4'h0);
            m[i]       = zero_above;
        end
        return m;
    endfunction
`endif

    assign upd_ready  = ~shadow_full_q;
    assign o_seg      = seg_q;
    assign o_sel      = sel_q;
    assign frame_done = frame_done_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        case (state_q)
            BLANK: begin
                if (cnt_q == CW'(BLANK_CYC - 1)) begin
                    state_d = DRIVE;
                    cnt_d   = '0;
                end
            end
            DRIVE: begin
                if (cnt_q == CW'(DIGIT_CYC - 1)) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    idx_d   = idx_q + 3'd1;
                end
            end
            default: begin
                state_d = BLANK;
                cnt_d   = '0;
            end
        endcase
    end

    // Commit needs a full shadow and transfer needs an empty one, so they never collide.
    always_comb begin
        disp_d        = disp_q;
        shadow_d      = shadow_q;
        shadow_full_d = shadow_full_q;
        if (frame_done_q && shadow_full_q) begin
            disp_d        = shadow_q;
            shadow_full_d = 1'b0;
        end
        if (upd_valid && upd_ready) begin
            shadow_d      = upd_data;
            shadow_full_d = 1'b1;
        end
    end

    assign nib = disp_d[{idx_d, 2'b00} +: 4];

    seg7_hex_decode u_dec (
        .nib_i (nib),
        .pat_o (pat)
    );

    // Outputs are registered from next-state so they change with the state itself.
    always_comb begin
        sel_d        = SEG_OFF;
        seg_d        = SEG_OFF;
        frame_done_d = 1'b0;
`ifdef SEG7_LZB_EN
        blank_mask   = lzb_mask(disp_d);
`endif
        if (state_d == DRIVE) begin
            sel_d = ~(8'b1 << idx_d);
            seg_d = {1'b1, pat};
`ifdef SEG7_LZB_EN
            if (blank_mask[idx_d]) begin
                seg_d = SEG_OFF;
            end
`endif
            frame_done_d = (idx_d == 3'(NUM_DIGITS - 1)) && (cnt_d == CW'(DIGIT_CYC - 1));
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q       <= BLANK;
            cnt_q         <= '0;
            idx_q         <= '0;
            disp_q        <= '0;
            shadow_q      <= '0;
            shadow_full_q <= 1'b0;
            sel_q         <= SEG_OFF;
            seg_q         <= SEG_OFF;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            disp_q        <= disp_d;
            shadow_q      <= shadow_d;
            shadow_full_q <= shadow_full_d;
            sel_q         <= sel_d;
            seg_q         <= seg_d;
            frame_done_q  <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with DIGIT_CYC=4, BLANK_CYC=2 (48-cycle frame).
module tb_seg7_scan_ctrl;

`ifdef SEG7_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk_in = 1'b0;
    logic        reset;
    logic        upd_valid;
    logic [31:0] upd_data;
    logic        upd_ready;
    logic [7:0]  o_seg;
    logic [7:0]  o_sel;
    logic        frame_done;

    int errors = 0;
    int checks = 0;
    int c      = 0;

    logic [6:0] pat_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    typedef struct {
        int         cyc;
        logic [7:0] sel;
        int         dig;
        logic       fd;
    } vec_t;

    vec_t vecs [13];

    seg7_scan_ctrl #(.DIGIT_CYC(4), .BLANK_CYC(2)) dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .upd_valid  (upd_valid),
        .upd_data   (upd_data),
        .upd_ready  (upd_ready),
        .o_seg      (o_seg),
        .o_sel      (o_sel),
        .frame_done (frame_done)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [7:0] exp_seg(input logic [31:0] v, input int d);
        logic [31:0] hi;
        hi = v >> (4 * d);
        if (LZB && d > 0 && hi == 32'h0) return 8'hFF;
        return {1'b1, pat_tab[hi[3:0]]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, c, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
        c++;
    endtask

    task automatic run_to(input int t);
        while (c < t) step();
    endtask

    initial begin
        reset     = 1'b1;
        upd_valid = 1'b0;
        upd_data  = 32'h0;

        vecs[0]  = '{0,  8'hFF, -1, 1'b0};
        vecs[1]  = '{1,  8'hFF, -1, 1'b0};
        vecs[2]  = '{2,  8'hFE,  0, 1'b0};
        vecs[3]  = '{5,  8'hFE,  0, 1'b0};
        vecs[4]  = '{6,  8'hFF, -1, 1'b0};
        vecs[5]  = '{8,  8'hFD,  1, 1'b0};
        vecs[6]  = '{11, 8'hFD,  1, 1'b0};
        vecs[7]  = '{44, 8'h7F,  7, 1'b0};
        vecs[8]  = '{47, 8'h7F,  7, 1'b1};
        vecs[9]  = '{48, 8'hFF, -1, 1'b0};
        vecs[10] = '{50, 8'hFE,  0, 1'b0};
        vecs[11] = '{95, 8'h7F,  7, 1'b1};
        vecs[12] = '{96, 8'hFF, -1, 1'b0};

        repeat (3) step();
        chk("rst_sel", o_sel, 8'hFF);
        chk("rst_seg", o_seg, 8'hFF);
        chk("rst_fd",  frame_done, 1'b0);
        chk("rst_rdy", upd_ready, 1'b1);
        reset = 1'b0;
        c = 0;

        // Idle scan with display 0
        for (int i = 0; i < 13; i++) begin
            run_to(vecs[i].cyc);
            chk("scan_sel", o_sel, vecs[i].sel);
            chk("scan_seg", o_seg, (vecs[i].dig < 0) ? 8'hFF : exp_seg(32'h0, vecs[i].dig));
            chk("scan_fd",  frame_done, vecs[i].fd);
            chk("scan_rdy", upd_ready, 1'b1);
        end

        // Mid-frame update, shown from next frame
        run_to(100);
        upd_valid = 1'b1;
        upd_data  = 32'h1234ABCD;
        step();
        upd_valid = 1'b0;
        chk("upd_rdy_low", upd_ready, 1'b0);
        run_to(104);
        chk("upd_cur_sel", o_sel, 8'hFD);
        chk("upd_cur_seg", o_seg, exp_seg(32'h0, 1));
        run_to(143);
        chk("upd_fd", frame_done, 1'b1);
        chk("upd_rdy_fd", upd_ready, 1'b0);
        step();
        chk("upd_rdy_rise", upd_ready, 1'b1);
        run_to(146);
        chk("upd_d0_sel", o_sel, 8'hFE);
        chk("upd_d0_seg", o_seg, 8'hA1);
        run_to(152);
        chk("upd_d1_sel", o_sel, 8'hFD);
        chk("upd_d1_seg", o_seg, 8'hC6);
        run_to(170);
        chk("upd_d4_sel", o_sel, 8'hEF);
        chk("upd_d4_seg", o_seg, 8'h99);
        run_to(188);
        chk("upd_d7_sel", o_sel, 8'h7F);
        chk("upd_d7_seg", o_seg, 8'hF9);

        // Back-to-back updates: second stalls until first commits
        run_to(200);
        upd_valid = 1'b1;
        upd_data  = 32'h1;
        step();
        chk("b2b_rdy1", upd_ready, 1'b0);
        upd_data = 32'h2;
        run_to(239);
        chk("b2b_fd", frame_done, 1'b1);
        chk("b2b_stall", upd_ready, 1'b0);
        step();
        chk("b2b_rdy_rise", upd_ready, 1'b1);
        step();
        chk("b2b_rdy2", upd_ready, 1'b0);
        upd_valid = 1'b0;
        run_to(242);
        chk("b2b_v1_d0", o_seg, exp_seg(32'h1, 0));
        run_to(248);
        chk("b2b_v1_d1", o_seg, exp_seg(32'h1, 1));
        run_to(287);
        chk("b2b_fd2", frame_done, 1'b1);
        run_to(290);
        chk("b2b_v2_d0", o_seg, exp_seg(32'h2, 0));
        run_to(296);
        chk("b2b_v2_d1", o_seg, exp_seg(32'h2, 1));

        // Transfer on the frame_done cycle: accepted, not committed until next frame end
        run_to(335);
        chk("sim_fd", frame_done, 1'b1);
        chk("sim_rdy", upd_ready, 1'b1);
        upd_valid = 1'b1;
        upd_data  = 32'h7;
        step();
        upd_valid = 1'b0;
        chk("sim_acc", upd_ready, 1'b0);
        run_to(338);
        chk("sim_nobypass", o_seg, exp_seg(32'h2, 0));
        run_to(383);
        chk("sim_fd2", frame_done, 1'b1);
        run_to(386);
        chk("sim_commit", o_seg, exp_seg(32'h7, 0));

        // Reset during digit 5 with the shadow full
        run_to(400);
        upd_valid = 1'b1;
        upd_data  = 32'h55555555;
        step();
        upd_valid = 1'b0;
        chk("mrst_full", upd_ready, 1'b0);
        run_to(417);
        chk("mrst_d5_sel", o_sel, 8'hDF);
        chk("mrst_d5_seg", o_seg, exp_seg(32'h7, 5));
        reset = 1'b1;
        step();
        chk("mrst_sel", o_sel, 8'hFF);
        chk("mrst_seg", o_seg, 8'hFF);
        chk("mrst_rdy", upd_ready, 1'b1);
        chk("mrst_fd",  frame_done, 1'b0);
        reset = 1'b0;
        c = 0;
        run_to(2);
        chk("mrst_d0_sel", o_sel, 8'hFE);
        chk("mrst_d0_seg", o_seg, 8'hC0);
        run_to(47);
        chk("mrst_fd_47", frame_done, 1'b1);
        run_to(50);
        chk("mrst_discard", o_seg, 8'hC0);

        // Leading-zero pattern 00000F00, then 0
        run_to(60);
        upd_valid = 1'b1;
        upd_data  = 32'h00000F00;
        step();
        upd_valid = 1'b0;
        run_to(98);
        chk("lz_d0", o_seg, 8'hC0);
        run_to(110);
        chk("lz_d2_sel", o_sel, 8'hFB);
        chk("lz_d2_seg", o_seg, 8'h8E);
        run_to(116);
        chk("lz_d3_sel", o_sel, 8'hF7);
        chk("lz_d3_seg", o_seg, exp_seg(32'h00000F00, 3));
        run_to(140);
        chk("lz_d7_sel", o_sel, 8'h7F);
        chk("lz_d7_seg", o_seg, exp_seg(32'h00000F00, 7));
        run_to(144);
        upd_valid = 1'b1;
        upd_data  = 32'h0;
        step();
        upd_valid = 1'b0;
        run_to(194);
        chk("lz0_d0", o_seg, 8'hC0);
        run_to(200);
        chk("lz0_d1_sel", o_sel, 8'hFD);
        chk("lz0_d1_seg", o_seg, exp_seg(32'h0, 1));
        run_to(206);
        chk("lz0_d2_seg", o_seg, exp_seg(32'h0, 2));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
